// File: rtl/e203_itcm_ram_ctrl_pkg.sv
// Shared definitions for the ITCM SRAM controller: low-power state encoding,
// requester port indices and the default idle threshold before light sleep.
package e203_itcm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_ACT  = 2'd0,
      ST_SLP  = 2'd1,
      ST_WAKE = 2'd2
   } lp_state_e;

   localparam int P_IFU       = 0;
   localparam int P_LSU       = 1;
   localparam int LS_IDLE_DEF = 16;

endpackage

// File: rtl/e203_itcm_ram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins;
// the last-grant pointer only moves when the granted command is accepted.
module e203_itcm_rr_arb2
   import e203_itcm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   logic r_last;

   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11) begin
         o_grant = (r_last == 1'(P_LSU)) ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 1'(P_LSU);
      end else if (i_accept) begin
         r_last <= o_grant[1];
      end
   end

endmodule

// File: rtl/e203_itcm_ram_ctrl.sv
// ITCM SRAM sequencer: arbitrates IFU/LSU onto a single-port macro with one access
// outstanding, returns responses one cycle later, and drives idle-based light sleep.
module e203_itcm_ram_ctrl
   import e203_itcm_ctrl_pkg::*;
#(
   parameter int AW      = 13,
   parameter int DW      = 64,
   parameter int MW      = 8,
   parameter int LS_IDLE = LS_IDLE_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_cmd_valid,
   output logic          p0_cmd_ready,
   input  logic          p0_cmd_read,
   input  logic [AW-1:0] p0_cmd_addr,
   input  logic [DW-1:0] p0_cmd_wdata,
   input  logic [MW-1:0] p0_cmd_wmask,
   output logic          p0_rsp_valid,
   input  logic          p0_rsp_ready,
   output logic [DW-1:0] p0_rsp_rdata,
   input  logic          p1_cmd_valid,
   output logic          p1_cmd_ready,
   input  logic          p1_cmd_read,
   input  logic [AW-1:0] p1_cmd_addr,
   input  logic [DW-1:0] p1_cmd_wdata,
   input  logic [MW-1:0] p1_cmd_wmask,
   output logic          p1_rsp_valid,
   input  logic          p1_rsp_ready,
   output logic [DW-1:0] p1_rsp_rdata,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [MW-1:0] ram_wem,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          ram_sd,
   output logic          ram_ds,
   output logic          ram_ls
);

   localparam int CNT_W = (LS_IDLE < 2) ? 1 : $clog2(LS_IDLE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LS_IDLE);

   lp_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ls;
   logic             r_pend;
   logic             r_owner;
   logic             r_rd;

   logic [1:0]       w_grant;
   logic             w_own_rdy, w_rsp_hs, w_can_issue, w_open;
   logic             w_hs0, w_hs1, w_issue, w_sel, w_read, w_any_valid;

   assign w_any_valid = p0_cmd_valid | p1_cmd_valid;
   assign w_own_rdy   = r_owner ? p1_rsp_ready : p0_rsp_ready;
   assign w_rsp_hs    = r_pend & w_own_rdy;
   assign w_can_issue = ~r_pend | w_rsp_hs;
   // Reset gates readiness so the macro never sees a chip select while rst is high.
   assign w_open      = w_can_issue & (r_state == ST_ACT) & ~rst;

   e203_itcm_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req    ({p1_cmd_valid, p0_cmd_valid}),
      .i_accept (w_issue),
      .o_grant  (w_grant)
   );

   assign p0_cmd_ready = w_grant[0] & w_open;
   assign p1_cmd_ready = w_grant[1] & w_open;
   assign w_hs0        = p0_cmd_valid & p0_cmd_ready;
   assign w_hs1        = p1_cmd_valid & p1_cmd_ready;
   assign w_issue      = w_hs0 | w_hs1;
   assign w_sel        = w_hs1;
   assign w_read       = w_sel ? p1_cmd_read : p0_cmd_read;

   assign ram_cs   = w_issue;
   assign ram_we   = w_issue & ~w_read;
   assign ram_addr = w_issue ? (w_sel ? p1_cmd_addr : p0_cmd_addr) : '0;
   assign ram_din  = w_issue ? (w_sel ? p1_cmd_wdata : p0_cmd_wdata) : '0;
   assign ram_wem  = ram_we ? (w_sel ? p1_cmd_wmask : p0_cmd_wmask) : '0;
   assign ram_sd   = 1'b0;
   assign ram_ds   = 1'b0;
   assign ram_ls   = r_ls;

   // The macro holds dout until the next read cs, so rdata needs no local copy.
   assign p0_rsp_valid = r_pend & (r_owner == 1'(P_IFU));
   assign p1_rsp_valid = r_pend & (r_owner == 1'(P_LSU));
   assign p0_rsp_rdata = (p0_rsp_valid & r_rd) ? ram_dout : '0;
   assign p1_rsp_rdata = (p1_rsp_valid & r_rd) ? ram_dout : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend  <= 1'b0;
         r_owner <= 1'b0;
         r_rd    <= 1'b0;
      end else if (w_issue) begin
         r_pend  <= 1'b1;
         r_owner <= w_sel;
         r_rd    <= w_read;
      end else if (w_rsp_hs) begin
         r_pend  <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACT;
         r_cnt   <= '0;
         r_ls    <= 1'b0;
      end else begin
         case (r_state)
            ST_ACT: begin
               if (w_any_valid | r_pend) begin
                  r_cnt <= '0;
               end else if ((LS_IDLE != 0) && (r_cnt == CNT_MAX - 1'b1)) begin
                  r_cnt   <= CNT_MAX;
                  r_state <= ST_SLP;
                  r_ls    <= 1'b1;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_SLP: begin
               if (w_any_valid) begin
                  r_state <= ST_WAKE;
                  r_ls    <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            ST_WAKE: begin
               r_state <= ST_ACT;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= ST_ACT;
               r_ls    <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_e203_itcm_ram_ctrl.sv
// Directed bench for the ITCM SRAM controller with a behavioural single-port SRAM
// (read data registered on a read cs, byte-masked writes).
module tb_e203_itcm_ram_ctrl;

   localparam int AW = 13;
   localparam int DW = 64;
   localparam int MW = 8;
   localparam logic [63:0] PRE = 64'h1122334455667788;

   logic          clk = 1'b0;
   logic          rst;
   logic          p0_cmd_valid, p0_cmd_ready, p0_cmd_read, p0_rsp_valid, p0_rsp_ready;
   logic [AW-1:0] p0_cmd_addr;
   logic [DW-1:0] p0_cmd_wdata, p0_rsp_rdata;
   logic [MW-1:0] p0_cmd_wmask;
   logic          p1_cmd_valid, p1_cmd_ready, p1_cmd_read, p1_rsp_valid, p1_rsp_ready;
   logic [AW-1:0] p1_cmd_addr;
   logic [DW-1:0] p1_cmd_wdata, p1_rsp_rdata;
   logic [MW-1:0] p1_cmd_wmask;
   logic          ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   e203_itcm_ram_ctrl #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .p0_cmd_valid (p0_cmd_valid),
      .p0_cmd_ready (p0_cmd_ready),
      .p0_cmd_read  (p0_cmd_read),
      .p0_cmd_addr  (p0_cmd_addr),
      .p0_cmd_wdata (p0_cmd_wdata),
      .p0_cmd_wmask (p0_cmd_wmask),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_ready (p0_rsp_ready),
      .p0_rsp_rdata (p0_rsp_rdata),
      .p1_cmd_valid (p1_cmd_valid),
      .p1_cmd_ready (p1_cmd_ready),
      .p1_cmd_read  (p1_cmd_read),
      .p1_cmd_addr  (p1_cmd_addr),
      .p1_cmd_wdata (p1_cmd_wdata),
      .p1_cmd_wmask (p1_cmd_wmask),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_ready (p1_rsp_ready),
      .p1_rsp_rdata (p1_rsp_rdata),
      .ram_cs       (ram_cs),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wem      (ram_wem),
      .ram_din      (ram_din),
      .ram_dout     (ram_dout),
      .ram_sd       (ram_sd),
      .ram_ds       (ram_ds),
      .ram_ls       (ram_ls)
   );

   // SRAM model; contents are re-initialised whenever rst is sampled high.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
         mem[16]  <= PRE;
         ram_dout <= '0;
      end else if (ram_cs) begin
         if (ram_we) begin
            for (int b = 0; b < MW; b++)
               if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      {p0_cmd_valid, p0_cmd_read, p0_cmd_addr, p0_cmd_wdata, p0_cmd_wmask} = '0;
      {p1_cmd_valid, p1_cmd_read, p1_cmd_addr, p1_cmd_wdata, p1_cmd_wmask} = '0;
      p0_rsp_ready = 1'b1;
      p1_rsp_ready = 1'b1;
      step;
      step;
      #1;
      check("rst_ram_cs", ram_cs, 0);
      check("rst_ram_ls", ram_ls, 0);
      check("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
      check("rst_ram_pins", {ram_we, ram_sd, ram_ds, ram_addr, ram_wem}, 0);
      check("rst_rdata", p0_rsp_rdata | p1_rsp_rdata | ram_din, 0);
      rst = 1'b0;
      #1;
      check("idle_cmd_ready", {p0_cmd_ready, p1_cmd_ready}, 0);

      // p0 read of pre-loaded word
      step;
      p0_cmd_valid = 1'b1; p0_cmd_read = 1'b1; p0_cmd_addr = 13'h010;
      #1;
      check("rd_cs_we", {ram_cs, ram_we}, 2'b10);
      check("rd_addr", ram_addr, 13'h010);
      check("rd_p0_ready", p0_cmd_ready, 1);
      step;
      p0_cmd_valid = 1'b0;
      #1;
      check("rd_p0_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 2'b10);
      check("rd_p0_rdata", p0_rsp_rdata, PRE);

      // p1 masked write then read-back
      step;
      p1_cmd_valid = 1'b1; p1_cmd_read = 1'b0; p1_cmd_addr = 13'h020;
      p1_cmd_wdata = '1; p1_cmd_wmask = 8'h0F;
      #1;
      check("wr_cs_we", {ram_cs, ram_we, p1_cmd_ready}, 3'b111);
      check("wr_wem", ram_wem, 8'h0F);
      check("wr_din", ram_din, 64'hFFFF_FFFF_FFFF_FFFF);
      step;
      check("wr_rsp", {p1_rsp_valid, p0_rsp_valid}, 2'b10);
      check("wr_rsp_rdata", p1_rsp_rdata, 0);
      p1_cmd_read = 1'b1;
      #1;
      check("rd2_issue_thru", {ram_cs, ram_we}, 2'b10);
      step;
      p1_cmd_valid = 1'b0;
      #1;
      check("rd2_rdata", p1_rsp_rdata, 64'h0000_0000_FFFF_FFFF);

      // Contention: pointer last pointed at p1, so p0 goes first
      step;
      p0_cmd_valid = 1'b1; p0_cmd_read = 1'b1; p0_cmd_addr = 13'h010;
      p1_cmd_valid = 1'b1; p1_cmd_read = 1'b1; p1_cmd_addr = 13'h020;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_ready_%0d", i), {p0_cmd_ready, p1_cmd_ready},
               (i % 2 == 0) ? 2'b10 : 2'b01);
         check($sformatf("rr_addr_%0d", i), ram_addr, (i % 2 == 0) ? 13'h010 : 13'h020);
         check($sformatf("rr_cs_%0d", i), ram_cs, 1);
         if (i > 0)
            check($sformatf("rr_rsp_%0d", i), {p0_rsp_valid, p1_rsp_valid},
                  (i % 2 == 1) ? 2'b10 : 2'b01);
         step;
      end
      p0_cmd_valid = 1'b0; p1_cmd_valid = 1'b0;
      check("rr_last_rdata", p1_rsp_rdata, 64'h0000_0000_FFFF_FFFF);

      // Back-pressure on p0 while p1 waits with a write
      p0_rsp_ready = 1'b0;
      p0_cmd_valid = 1'b1; p0_cmd_addr = 13'h010;
      #1;
      check("bp_issue", {p0_cmd_ready, ram_cs}, 2'b11);
      step;
      p0_cmd_valid = 1'b0;
      p1_cmd_valid = 1'b1; p1_cmd_read = 1'b0; p1_cmd_addr = 13'h030;
      p1_cmd_wdata = 64'hA5A5_5A5A_0F0F_F0F0; p1_cmd_wmask = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_rsp_%0d", i), {p0_rsp_valid, p1_rsp_valid}, 2'b10);
         check($sformatf("bp_rdata_%0d", i), p0_rsp_rdata, PRE);
         check($sformatf("bp_stall_%0d", i), {p0_cmd_ready, p1_cmd_ready, ram_cs}, 0);
         step;
      end
      p0_rsp_ready = 1'b1;
      #1;
      check("bp_release", {p1_cmd_ready, ram_cs, ram_we}, 3'b111);
      check("bp_release_rdata", p0_rsp_rdata, PRE);
      step;
      p1_cmd_valid = 1'b0;
      #1;
      check("bp_p1_rsp", {p0_rsp_valid, p1_rsp_valid}, 2'b01);
      check("bp_p1_rdata", p1_rsp_rdata, 0);
      step;

      // Async reset with p1 response pending
      p1_rsp_ready = 1'b0;
      p1_cmd_valid = 1'b1; p1_cmd_read = 1'b1; p1_cmd_addr = 13'h020;
      #1;
      check("ar_issue", p1_cmd_ready, 1);
      step;
      p1_cmd_valid = 1'b0;
      p0_cmd_valid = 1'b1; p0_cmd_read = 1'b1; p0_cmd_addr = 13'h010;
      #1;
      check("ar_pending", {p1_rsp_valid, ram_cs}, 2'b10);
      p1_rsp_ready = 1'b1;
      #1;
      check("ar_next_issue", ram_cs, 1);
      #2;
      rst = 1'b1;
      p1_cmd_valid = 1'b1;
      #1;
      check("ar_rsp_dropped", {p1_rsp_valid, p0_rsp_valid}, 0);
      check("ar_cs_dropped", {ram_cs, p0_cmd_ready, p1_cmd_ready}, 0);
      check("ar_rdata_dropped", p1_rsp_rdata, 0);
      step;
      rst = 1'b0;
      #1;
      check("ar_first_tie", {p0_cmd_ready, p1_cmd_ready}, 2'b10);

      // Light sleep from a fresh reset
      p0_cmd_valid = 1'b0; p1_cmd_valid = 1'b0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      for (int i = 0; i < 15; i++) step;
      check("ls_before", ram_ls, 0);
      step;
      check("ls_entered", ram_ls, 1);
      p0_cmd_valid = 1'b1; p0_cmd_read = 1'b1; p0_cmd_addr = 13'h010;
      #1;
      check("ls_slp_blocked", {p0_cmd_ready, ram_cs, ram_ls}, 3'b001);
      step;
      check("ls_wake", {ram_ls, p0_cmd_ready, ram_cs}, 0);
      step;
      check("ls_act_accept", {ram_ls, p0_cmd_ready, ram_cs}, 3'b011);
      step;
      p0_cmd_valid = 1'b0;
      #1;
      check("ls_rdata", p0_rsp_rdata, PRE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
